// File: rtl/square_gen_param.sv
// square_gen_param: programmable square-wave generator.
//
// Runs a period counter over Per_a cycles and drives Pulse high while the
// counter is below Hi_a. New Period/High_Time values captured by Load are
// held as a pending pair. They are copied into the active pair only at a
// period boundary, so a running period always completes unchanged.
//
// Optional feature, macro SQUARE_BURST_EN: adds an ARMED state. Trigger then
// starts a burst of Burst_Count periods (0 = continuous). Burst_Done pulses
// for one cycle when the burst has finished.
//
// Ports:
//   sysclk       in   clock, all logic on the rising edge
//   Reset_n      in   synchronous active-low reset
//   Enable       in   run request
//   Period       in   CNT_W  period in cycles, captured on Load
//   High_Time    in   CNT_W  high cycles per period, captured on Load
//   Load         in   capture strobe for Period/High_Time
//   Trigger      in   burst start strobe (burst build only)
//   Burst_Count  in   BURST_W periods per burst, 0 = continuous
//   Pulse        out  registered square wave
//   Period_Start out  strobe in the first cycle of every period
//   Burst_Done   out  strobe after the last period of a burst
module square_gen_param #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               sysclk,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic [CNT_W-1:0]   Period,
  input  logic [CNT_W-1:0]   High_Time,
  input  logic               Load,
  input  logic               Trigger,
  input  logic [BURST_W-1:0] Burst_Count,
  output logic               Pulse,
  output logic               Period_Start,
  output logic               Burst_Done
);

`ifdef SQUARE_BURST_EN
  typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;     // active pair
  logic [CNT_W-1:0] pper_q, pper_d, phi_q, phi_d; // pending pair
  logic             pend_q, pend_d;
  logic             pulse_q, pulse_d, ps_q, ps_d;
  logic             wrap;
  logic [CNT_W-1:0] new_per, new_hi;
  logic             new_vld;

`ifdef SQUARE_BURST_EN
  logic [BURST_W-1:0] rem_q, rem_d;  // periods left in burst, 0 = continuous
  logic               done_q, done_d;
`else
  logic unused_burst;
  assign unused_burst = ^{Trigger, Burst_Count};
`endif

  // Periods of 0 or 1 collapse to a single cycle, so every cycle wraps.
  assign wrap = (per_q <= CNT_W'(1)) || (cnt_q >= per_q - CNT_W'(1));

  // Values to install at a boundary: a Load in this very cycle wins over an
  // older pending pair.
  assign new_per = Load ? Period    : pper_q;
  assign new_hi  = Load ? High_Time : phi_q;
  assign new_vld = Load | pend_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    hi_d   = hi_q;
    pper_d = pper_q;
    phi_d  = phi_q;
    pend_d = pend_q;
`ifdef SQUARE_BURST_EN
    rem_d  = rem_q;
    done_d = 1'b0;
`endif
    case (st_q)
      RUN: begin
        if (!Enable) begin
          st_d  = IDLE;
          cnt_d = '0;
          if (Load) begin
            pper_d = Period;
            phi_d  = High_Time;
            pend_d = 1'b1;
          end
        end else if (wrap) begin
          cnt_d = '0;
          if (new_vld) begin
            per_d  = new_per;
            hi_d   = new_hi;
            pend_d = 1'b0;
          end
`ifdef SQUARE_BURST_EN
          if (rem_q == BURST_W'(1)) begin
            st_d   = ARMED;
            done_d = 1'b1;
          end
          if (rem_q != '0) rem_d = rem_q - BURST_W'(1);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (Load) begin
            pper_d = Period;
            phi_d  = High_Time;
            pend_d = 1'b1;
          end
        end
      end
      default: begin
        // Not generating: no period to protect, install new values at once.
        cnt_d = '0;
        if (new_vld) begin
          per_d  = new_per;
          hi_d   = new_hi;
          pend_d = 1'b0;
        end
`ifdef SQUARE_BURST_EN
        if (st_q == IDLE) begin
          if (Enable) st_d = ARMED;
        end else if (!Enable) begin
          st_d = IDLE;
        end else if (Trigger) begin
          st_d  = RUN;
          rem_d = Burst_Count;
        end
`else
        if (Enable) st_d = RUN;
`endif
      end
    endcase
    // Outputs are derived from next-state values so they are registered
    // yet still appear one cycle after the input sample.
    pulse_d = (st_d == RUN) && (cnt_d < hi_d);
    ps_d    = (st_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      pper_q  <= '0;
      phi_q   <= '0;
      pend_q  <= 1'b0;
      pulse_q <= 1'b0;
      ps_q    <= 1'b0;
`ifdef SQUARE_BURST_EN
      rem_q   <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      pper_q  <= pper_d;
      phi_q   <= phi_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      ps_q    <= ps_d;
`ifdef SQUARE_BURST_EN
      rem_q   <= rem_d;
      done_q  <= done_d;
`endif
    end
  end

  assign Pulse        = pulse_q;
  assign Period_Start = ps_q;
`ifdef SQUARE_BURST_EN
  assign Burst_Done   = done_q;
`else
  assign Burst_Done   = 1'b0;
`endif

endmodule

// File: doc/square_gen_param.md
SQUARE_GEN_PARAM -- requirements
Module: square_gen_param

Interface
REQ-001 Parameter CNT_W, default 16: width of the period, high-time and internal counter.
REQ-002 Parameter BURST_W, default 8: width of the burst count (used only with SQUARE_BURST_EN).
REQ-003 sysclk  in  1  single clock; all logic on rising edge.
REQ-004 Reset_n  in  1  reset, synchronous, active-low.
REQ-005 Enable  in  1  run request; high = generate, low = idle.
REQ-006 Period  in  CNT_W  period in sysclk cycles, captured on Load.
REQ-007 High_Time  in  CNT_W  high cycles per period, captured on Load.
REQ-008 Load  in  1  one-cycle strobe; captures Period/High_Time into pending registers.
REQ-009 Trigger  in  1  one-cycle burst start strobe.
REQ-010 Burst_Count  in  BURST_W  periods per burst; 0 = continuous.
REQ-011 Pulse  out  1  registered square-wave output.
REQ-012 Period_Start  out  1  one-cycle strobe in the first cycle of every period.
REQ-013 Burst_Done  out  1  one-cycle strobe after the last period of a burst.

Function
REQ-014 The block SHALL hold active registers Per_a and Hi_a, a pending pair with a pending flag, and a counter cnt (0..Per_a-1).
REQ-015 States SHALL be IDLE and RUN; with SQUARE_BURST_EN, also ARMED.
REQ-016 IDLE->RUN SHALL occur when Enable=1 is sampled; the first RUN cycle SHALL have cnt=0, Period_Start=1, and Pulse=1 if Hi_a>0.
REQ-017 In RUN, Pulse SHALL be 1 exactly when cnt<Hi_a.
REQ-018 cnt SHALL wrap from Per_a-1 to 0, and Period_Start SHALL be 1 in every cycle with cnt=0.
REQ-019 Per_a of 0 or 1 SHALL give a 1-cycle period: cnt held at 0 and Period_Start high every cycle.
REQ-020 Hi_a>=Per_a SHALL give Pulse constantly 1.
REQ-021 Hi_a=0 SHALL give Pulse constantly 0, while Period_Start keeps toggling.
REQ-022 Load in RUN SHALL copy the pending pair into the active pair at the next wrap only; the current period SHALL complete unchanged (glitch-free).
REQ-023 Load in the same cycle as a wrap SHALL take effect at that wrap.
REQ-024 Load in IDLE SHALL update Per_a/Hi_a on the next cycle.
REQ-025 Two Loads before a wrap SHALL keep only the last values.
REQ-026 Enable sampled 0 in RUN SHALL, on the next cycle, force state IDLE, cnt=0, Pulse=0 and Period_Start=0, even mid-high-phase.
REQ-027 Pending values SHALL survive an Enable drop.
REQ-028 Total latency from an input sample to Pulse SHALL be one cycle, with no combinational path from inputs to outputs.

Reset
REQ-029 Reset_n=0 sampled SHALL set state=IDLE, cnt=0, Pulse=0, Period_Start=0, Burst_Done=0, pending flag=0, Per_a=0, Hi_a=0.
REQ-030 Reset SHALL take priority over Enable, Load and Trigger in the same cycle.
REQ-031 Reset mid-period SHALL discard the period, and the first period after reset SHALL be a full period.

Configuration
REQ-032 Macro SQUARE_BURST_EN defined: Enable=1 SHALL go IDLE->ARMED; Trigger in ARMED SHALL start RUN for Burst_Count periods.
REQ-033 After the last period completes, the block SHALL return to ARMED with Burst_Done=1 for one cycle, Pulse=0 and Period_Start=0.
REQ-034 Burst_Count=0 SHALL mean continuous RUN, and Trigger during RUN SHALL be ignored.
REQ-035 Macro SQUARE_BURST_EN undefined: Trigger and Burst_Count SHALL be ignored, Burst_Done SHALL be tied 0, and no ARMED state or burst counter SHALL be synthesised.

Verification
REQ-036 Load Period=10, High_Time=3, Enable=1 -> Pulse repeats 3 high / 7 low, Period_Start every 10 cycles, first high cycle one cycle after Enable is sampled.
REQ-037 Running 10/3, Load 4/2 at cnt=5 -> current period finishes as 10/3, then 2 high / 2 low from the wrap.
REQ-038 High_Time=12, Period=8 -> Pulse constant 1; High_Time=0 -> Pulse constant 0 with Period_Start every 8 cycles.
REQ-039 Running 10/3, Enable=0 at cnt=1 -> Pulse=0 next cycle; re-enable -> fresh period with cnt=0 and 3 high cycles.
REQ-040 Reset_n=0 for 1 cycle at cnt=6 -> all outputs 0 next cycle; Per_a/Hi_a cleared, so Pulse stays 0 until a new Load.
REQ-041 (SQUARE_BURST_EN) Period=5, High_Time=2, Burst_Count=3, Trigger -> exactly 3 pulses, Burst_Done one cycle after the 15th cycle, then Pulse=0 until the next Trigger.
